// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch/decode/exec/mem/wb,
// handles the memory ready handshake, bus timeout and retired-instruction counting.
module multicycle_control #(
    parameter int COUNT_W   = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [6:0]         OPCODE,
    input  logic               BR_COND,
    input  logic               MEM_READY,
    output logic               MEM_REQ,
    output logic               MEM_WE,
    output logic               I_OR_D,
    output logic               IR_WRITE,
    output logic               PC_WRITE,
    output logic [1:0]         PC_SRC,
    output logic [1:0]         ALU_SRC_A,
    output logic [1:0]         ALU_SRC_B,
    output logic [1:0]         ALU_OP,
    output logic               REG_WRITE,
    output logic [1:0]         WB_SEL,
    output logic               ILLEGAL,
    output logic               BUS_ERROR,
    output logic [2:0]         STATE,
    output logic [COUNT_W-1:0] RETIRED_COUNT
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // The counter only ever increments to all-ones on the timeout edge itself.
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [TIMEOUT_W-1:0] WAIT_ONE  = TIMEOUT_W'(1);
    localparam logic [COUNT_W-1:0]   CNT_ONE   = COUNT_W'(1);

    logic [2:0]           state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic                 bus_error_q, bus_error_d;
    logic [COUNT_W-1:0]   retired_q, retired_d;
    logic                 retire;
    logic                 timeout;

    always_comb begin
        MEM_REQ   = 1'b0;
        MEM_WE    = 1'b0;
        I_OR_D    = 1'b0;
        IR_WRITE  = 1'b0;
        PC_WRITE  = 1'b0;
        PC_SRC    = 2'b00;
        ALU_SRC_A = 2'b00;
        ALU_SRC_B = 2'b00;
        ALU_OP    = 2'b00;
        REG_WRITE = 1'b0;
        WB_SEL    = 2'b00;
        ILLEGAL   = 1'b0;
        retire    = 1'b0;
        state_d   = state_q;

        case (state_q)
            S_FETCH: begin
                MEM_REQ   = 1'b1;
                ALU_SRC_B = 2'b01;
                if (MEM_READY) begin
                    IR_WRITE = 1'b1;
                    PC_WRITE = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                ALU_SRC_A = 2'b10;
                ALU_SRC_B = 2'b10;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WB;
                case (OPCODE)
                    OP_R: begin
                        ALU_SRC_A = 2'b01;
                        ALU_OP    = 2'b10;
                    end
                    OP_I: begin
                        ALU_SRC_A = 2'b01;
                        ALU_SRC_B = 2'b10;
                        ALU_OP    = 2'b10;
                    end
                    OP_LOAD, OP_STORE: begin
                        ALU_SRC_A = 2'b01;
                        ALU_SRC_B = 2'b10;
                        state_d   = S_MEM;
                    end
                    OP_LUI: begin
                        ALU_SRC_A = 2'b11;
                        ALU_SRC_B = 2'b10;
                    end
                    OP_AUIPC: begin
                        ALU_SRC_A = 2'b10;
                        ALU_SRC_B = 2'b10;
                    end
                    OP_BR: begin
                        ALU_SRC_A = 2'b01;
                        ALU_OP    = 2'b01;
                        PC_WRITE  = BR_COND;
                        PC_SRC    = 2'b01;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                    OP_JAL: begin
                        REG_WRITE = 1'b1;
                        WB_SEL    = 2'b10;
                        PC_WRITE  = 1'b1;
                        PC_SRC    = 2'b01;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                    OP_JALR: begin
                        ALU_SRC_A = 2'b01;
                        ALU_SRC_B = 2'b10;
                        REG_WRITE = 1'b1;
                        WB_SEL    = 2'b10;
                        PC_WRITE  = 1'b1;
                        PC_SRC    = 2'b10;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                    default: begin
                        ILLEGAL = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                MEM_REQ = 1'b1;
                I_OR_D  = 1'b1;
                MEM_WE  = (OPCODE == OP_STORE);
                if (MEM_READY) begin
                    if (OPCODE == OP_STORE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                REG_WRITE = 1'b1;
                WB_SEL    = (OPCODE == OP_LOAD) ? 2'b01 : 2'b00;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        timeout = MEM_REQ && !MEM_READY && (wait_q == WAIT_LAST);
        if (timeout) begin
            state_d = S_HALT;
        end

        wait_d = wait_q;
        if (MEM_READY || ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))) begin
            wait_d = '0;
        end else if (MEM_REQ) begin
            wait_d = wait_q + WAIT_ONE;
        end

        bus_error_d = bus_error_q | timeout;
        retired_d   = retire ? (retired_q + CNT_ONE) : retired_q;

        // Reset forces every strobe low at once, not just at the next edge.
        if (!RESET_N) begin
            MEM_REQ   = 1'b0;
            MEM_WE    = 1'b0;
            I_OR_D    = 1'b0;
            IR_WRITE  = 1'b0;
            PC_WRITE  = 1'b0;
            PC_SRC    = 2'b00;
            ALU_SRC_A = 2'b00;
            ALU_SRC_B = 2'b00;
            ALU_OP    = 2'b00;
            REG_WRITE = 1'b0;
            WB_SEL    = 2'b00;
            ILLEGAL   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_FETCH;
            wait_q      <= '0;
            bus_error_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            bus_error_q <= bus_error_d;
            retired_q   <= retired_d;
        end
    end

    assign STATE         = state_q;
    assign BUS_ERROR     = bus_error_q;
    assign RETIRED_COUNT = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each stimulus cycle queues its expected
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [6:0] OPCODE;
    logic       BR_COND;
    logic       MEM_READY;
    logic       MEM_REQ, MEM_WE, I_OR_D, IR_WRITE, PC_WRITE, REG_WRITE, ILLEGAL, BUS_ERROR;
    logic [1:0] PC_SRC, ALU_SRC_A, ALU_SRC_B, ALU_OP, WB_SEL;
    logic [2:0] STATE;
    logic [3:0] RETIRED_COUNT;

    always #5 CLK = ~CLK;

    multicycle_control #(.COUNT_W(4), .TIMEOUT_W(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .OPCODE(OPCODE), .BR_COND(BR_COND),
        .MEM_READY(MEM_READY), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .I_OR_D(I_OR_D),
        .IR_WRITE(IR_WRITE), .PC_WRITE(PC_WRITE), .PC_SRC(PC_SRC), .ALU_SRC_A(ALU_SRC_A),
        .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP), .REG_WRITE(REG_WRITE), .WB_SEL(WB_SEL),
        .ILLEGAL(ILLEGAL), .BUS_ERROR(BUS_ERROR), .STATE(STATE), .RETIRED_COUNT(RETIRED_COUNT)
    );

    // {state, ctl, sel, count}
    //   ctl = {MEM_REQ, MEM_WE, I_OR_D, IR_WRITE, PC_WRITE, REG_WRITE, ILLEGAL, BUS_ERROR}
    //   sel = {PC_SRC, ALU_SRC_A, ALU_SRC_B, ALU_OP, WB_SEL}
    typedef logic [24:0] exp_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    localparam logic [7:0] C_NONE  = 8'b0000_0000;
    localparam logic [7:0] C_FWAIT = 8'b1000_0000;
    localparam logic [7:0] C_FRDY  = 8'b1001_1000;
    localparam logic [7:0] C_MLD   = 8'b1010_0000;
    localparam logic [7:0] C_MST   = 8'b1110_0000;
    localparam logic [7:0] C_WB    = 8'b0000_0100;
    localparam logic [7:0] C_BRT   = 8'b0000_1000;
    localparam logic [7:0] C_JMP   = 8'b0000_1100;
    localparam logic [7:0] C_ILL   = 8'b0000_0010;
    localparam logic [7:0] C_HALT  = 8'b0000_0001;

    localparam logic [9:0] S_NONE  = 10'b00_00_00_00_00;
    localparam logic [9:0] S_FET   = 10'b00_00_01_00_00;
    localparam logic [9:0] S_DEC   = 10'b00_10_10_00_00;
    localparam logic [9:0] S_XR    = 10'b00_01_00_10_00;
    localparam logic [9:0] S_XI    = 10'b00_01_10_10_00;
    localparam logic [9:0] S_XMEM  = 10'b00_01_10_00_00;
    localparam logic [9:0] S_XLUI  = 10'b00_11_10_00_00;
    localparam logic [9:0] S_XAUI  = 10'b00_10_10_00_00;
    localparam logic [9:0] S_XBR   = 10'b01_01_00_01_00;
    localparam logic [9:0] S_XJAL  = 10'b01_00_00_00_10;
    localparam logic [9:0] S_XJALR = 10'b10_01_10_00_10;
    localparam logic [9:0] S_WBLD  = 10'b00_00_00_00_01;

    exp_t  exp_q[$];
    string tag_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [24:0] act;
    assign act = {STATE, MEM_REQ, MEM_WE, I_OR_D, IR_WRITE, PC_WRITE, REG_WRITE, ILLEGAL,
                  BUS_ERROR, PC_SRC, ALU_SRC_A, ALU_SRC_B, ALU_OP, WB_SEL, RETIRED_COUNT};

    function automatic exp_t e(input logic [2:0] st, input logic [7:0] ctl,
                               input logic [9:0] sel, input logic [3:0] cnt);
        return {st, ctl, sel, cnt};
    endfunction

    always @(negedge CLK) begin
        exp_t  x;
        string t;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act !== x) begin
                errors++;
                $display("FAIL %s: got state=%0d ctl=%b sel=%b cnt=%0d, want state=%0d ctl=%b sel=%b cnt=%0d",
                         t, act[24:22], act[21:14], act[13:4], act[3:0],
                         x[24:22], x[21:14], x[13:4], x[3:0]);
            end
        end
    end

    task automatic cyc(input logic rst, input logic rdy, input logic br, input logic [6:0] op,
                       input string tag, input exp_t x);
        @(posedge CLK);
        #1;
        RESET_N   = rst;
        MEM_READY = rdy;
        BR_COND   = br;
        OPCODE    = op;
        exp_q.push_back(x);
        tag_q.push_back(tag);
    endtask

    task automatic fetch_dec(input logic [6:0] op, input logic [3:0] cnt);
        cyc(1'b1, 1'b1, 1'b0, op, "fetch", e(3'd0, C_FRDY, S_FET, cnt));
        cyc(1'b1, 1'b0, 1'b0, op, "decode", e(3'd1, C_NONE, S_DEC, cnt));
    endtask

    initial begin
        RESET_N   = 1'b0;
        MEM_READY = 1'b0;
        BR_COND   = 1'b0;
        OPCODE    = '0;

        cyc(1'b0, 1'b0, 1'b0, OP_R, "reset", e(3'd0, C_NONE, S_NONE, 4'd0));
        cyc(1'b0, 1'b1, 1'b0, OP_R, "reset_rdy", e(3'd0, C_NONE, S_NONE, 4'd0));

        // R-type ADD: 0,1,2,4
        fetch_dec(OP_R, 4'd0);
        cyc(1'b1, 1'b0, 1'b0, OP_R, "exec_r", e(3'd2, C_NONE, S_XR, 4'd0));
        cyc(1'b1, 1'b0, 1'b0, OP_R, "wb_r", e(3'd4, C_WB, S_NONE, 4'd0));

        // load, ready on the third cycle of both FETCH and MEM: 9 cycles
        cyc(1'b1, 1'b0, 1'b0, OP_LD, "ld_fetch_wait", e(3'd0, C_FWAIT, S_FET, 4'd1));
        cyc(1'b1, 1'b0, 1'b0, OP_LD, "ld_fetch_wait", e(3'd0, C_FWAIT, S_FET, 4'd1));
        fetch_dec(OP_LD, 4'd1);
        cyc(1'b1, 1'b0, 1'b0, OP_LD, "exec_ld", e(3'd2, C_NONE, S_XMEM, 4'd1));
        cyc(1'b1, 1'b0, 1'b0, OP_LD, "ld_mem_wait", e(3'd3, C_MLD, S_NONE, 4'd1));
        cyc(1'b1, 1'b0, 1'b0, OP_LD, "ld_mem_wait", e(3'd3, C_MLD, S_NONE, 4'd1));
        cyc(1'b1, 1'b1, 1'b0, OP_LD, "ld_mem_rdy", e(3'd3, C_MLD, S_NONE, 4'd1));
        cyc(1'b1, 1'b0, 1'b0, OP_LD, "wb_ld", e(3'd4, C_WB, S_WBLD, 4'd1));

        // branches, not taken then taken
        fetch_dec(OP_BR, 4'd2);
        cyc(1'b1, 1'b0, 1'b0, OP_BR, "exec_br_nt", e(3'd2, C_NONE, S_XBR, 4'd2));
        fetch_dec(OP_BR, 4'd3);
        cyc(1'b1, 1'b0, 1'b1, OP_BR, "exec_br_t", e(3'd2, C_BRT, S_XBR, 4'd3));

        // illegal opcode: no writes, count unchanged
        fetch_dec(OP_BAD, 4'd4);
        cyc(1'b1, 1'b0, 1'b0, OP_BAD, "exec_illegal", e(3'd2, C_ILL, S_NONE, 4'd4));

        // store, zero wait states
        fetch_dec(OP_ST, 4'd4);
        cyc(1'b1, 1'b0, 1'b0, OP_ST, "exec_st", e(3'd2, C_NONE, S_XMEM, 4'd4));
        cyc(1'b1, 1'b1, 1'b0, OP_ST, "st_mem_rdy", e(3'd3, C_MST, S_NONE, 4'd4));

        fetch_dec(OP_JAL, 4'd5);
        cyc(1'b1, 1'b0, 1'b0, OP_JAL, "exec_jal", e(3'd2, C_JMP, S_XJAL, 4'd5));
        fetch_dec(OP_JALR, 4'd6);
        cyc(1'b1, 1'b0, 1'b0, OP_JALR, "exec_jalr", e(3'd2, C_JMP, S_XJALR, 4'd6));

        fetch_dec(OP_I, 4'd7);
        cyc(1'b1, 1'b0, 1'b0, OP_I, "exec_i", e(3'd2, C_NONE, S_XI, 4'd7));
        cyc(1'b1, 1'b0, 1'b0, OP_I, "wb_i", e(3'd4, C_WB, S_NONE, 4'd7));
        fetch_dec(OP_LUI, 4'd8);
        cyc(1'b1, 1'b0, 1'b0, OP_LUI, "exec_lui", e(3'd2, C_NONE, S_XLUI, 4'd8));
        cyc(1'b1, 1'b0, 1'b0, OP_LUI, "wb_lui", e(3'd4, C_WB, S_NONE, 4'd8));
        fetch_dec(OP_AUIPC, 4'd9);
        cyc(1'b1, 1'b0, 1'b0, OP_AUIPC, "exec_auipc", e(3'd2, C_NONE, S_XAUI, 4'd9));
        cyc(1'b1, 1'b0, 1'b0, OP_AUIPC, "wb_auipc", e(3'd4, C_WB, S_NONE, 4'd9));

        // seven more JALs: 17 retired in total, 4-bit count wraps to 1
        for (int i = 0; i < 7; i++) begin
            logic [3:0] c;
            c = 4'(10 + i);
            fetch_dec(OP_JAL, c);
            cyc(1'b1, 1'b0, 1'b0, OP_JAL, "exec_jal_wrap", e(3'd2, C_JMP, S_XJAL, c));
        end

        // store interrupted by reset while waiting in MEM
        fetch_dec(OP_ST, 4'd1);
        cyc(1'b1, 1'b0, 1'b0, OP_ST, "exec_st2", e(3'd2, C_NONE, S_XMEM, 4'd1));
        cyc(1'b1, 1'b0, 1'b0, OP_ST, "st_mem_wait", e(3'd3, C_MST, S_NONE, 4'd1));
        cyc(1'b0, 1'b0, 1'b0, OP_ST, "reset_mid_mem", e(3'd0, C_NONE, S_NONE, 4'd0));

        // MEM_READY in the last cycle before timeout wins
        for (int i = 0; i < 254; i++)
            cyc(1'b1, 1'b0, 1'b0, OP_BAD, "fetch_long_wait", e(3'd0, C_FWAIT, S_FET, 4'd0));
        cyc(1'b1, 1'b1, 1'b0, OP_BAD, "fetch_rdy_at_limit", e(3'd0, C_FRDY, S_FET, 4'd0));
        cyc(1'b1, 1'b0, 1'b0, OP_BAD, "decode_after_limit", e(3'd1, C_NONE, S_DEC, 4'd0));
        cyc(1'b1, 1'b0, 1'b0, OP_BAD, "exec_illegal2", e(3'd2, C_ILL, S_NONE, 4'd0));

        // timeout: 255 FETCH cycles without ready, then HALT with BUS_ERROR
        for (int i = 0; i < 255; i++)
            cyc(1'b1, 1'b0, 1'b0, OP_BAD, "fetch_timeout_wait", e(3'd0, C_FWAIT, S_FET, 4'd0));
        cyc(1'b1, 1'b0, 1'b0, OP_BAD, "halt_entry", e(3'd7, C_HALT, S_NONE, 4'd0));
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, 1'b0, OP_R, "halt_hold", e(3'd7, C_HALT, S_NONE, 4'd0));
        cyc(1'b0, 1'b0, 1'b0, OP_R, "halt_reset", e(3'd0, C_NONE, S_NONE, 4'd0));
        cyc(1'b1, 1'b0, 1'b0, OP_R, "after_halt_reset", e(3'd0, C_FWAIT, S_FET, 4'd0));

        repeat (2) @(posedge CLK);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
